mul_product_collector: RTL and testbench

- Downstream stage of the 5-bit, unfolding-factor-2 bit-serial multiplier.
- The multiplier emits a product on s_0 at phase 2 and on s_1 at phase 4 of its 5-cycle frame, and drives zero at all other phases.
- This block tracks the same frame and captures each product. It forwards products through a small first-word-fall-through FIFO with a valid/ready output, and sums groups of ACC_LEN products into a dot-product result.

---
 rtl/mul_product_collector.sv | 137 +++++++++++++
 tb/tb_mul_product_collector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_product_collector.sv
// Collects the products of the unfolded bit-serial multiplier on its frame phases,
// queues them in a first-word-fall-through FIFO and sums groups of ACC_LEN products.
module mul_product_collector #(
    parameter int IN_W       = 10,
    parameter int PERIOD     = 5,
    parameter int PH0        = 2,
    parameter int PH1        = 4,
    parameter int ACC_LEN    = 4,
    parameter int OUT_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_W-1:0]               s_0,
    input  logic [IN_W-1:0]               s_1,
    output logic [IN_W-1:0]               dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [OUT_W-1:0]              acc_out,
    output logic                          acc_valid,
    output logic                          drop_err
);

    localparam int PH_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(ACC_LEN + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0]  PH0_C    = PH_W'(PH0);
    localparam logic [PH_W-1:0]  PH1_C    = PH_W'(PH1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    logic [PH_W-1:0]  r_phase;
    logic [IN_W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LVL_W-1:0] r_level;
    logic             r_drop;
    logic [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_acc_out;
    logic             r_acc_valid;

    logic             w_cap0;
    logic             w_cap1;
    logic             w_cap;
    logic [IN_W-1:0]  w_prod;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [OUT_W-1:0] w_sum;

    // Phase counter mirrors the multiplier's frame counter.
    always_ff @(posedge clk) begin
        if (reset)
            r_phase <= '0;
        else if (r_phase == PH_LAST)
            r_phase <= '0;
        else
            r_phase <= r_phase + 1'b1;
    end

    assign w_cap0 = (r_phase == PH0_C);
    assign w_cap1 = (r_phase == PH1_C);
    assign w_cap  = w_cap0 | w_cap1;
    assign w_prod = w_cap0 ? s_0 : s_1;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);
    assign w_pop   = !w_empty && dout_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the product.
    assign w_push  = w_cap && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)
                r_level <= r_level + 1'b1;
            else if (w_pop && !w_push)
                r_level <= r_level - 1'b1;
            if (w_cap && !w_push)
                r_drop <= 1'b1;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= w_prod;
    end

    assign dout       = w_empty ? '0 : r_mem[r_rd];
    assign dout_valid = !w_empty;
    assign fifo_level = r_level;
    assign drop_err   = r_drop;

    assign w_sum = r_acc + {{(OUT_W - IN_W){1'b0}}, w_prod};

    // Accumulator sees every captured product, independent of FIFO drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_acc_out   <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= 1'b0;
            if (w_cap) begin
                if (r_cnt == CNT_LAST) begin
                    r_acc_out   <= w_sum;
                    r_acc_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign acc_out   = r_acc_out;
    assign acc_valid = r_acc_valid;

endmodule

// File: tb/tb_mul_product_collector.sv
// Directed bench for mul_product_collector: drives products on the frame phases
// the multiplier uses and checks FIFO, drop and accumulation behaviour.
module tb_mul_product_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  s_0;
    logic [9:0]  s_1;
    logic [9:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  fifo_level;
    logic [11:0] acc_out;
    logic        acc_valid;
    logic        drop_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mul_product_collector dut (
        .clk        (clk),
        .reset      (reset),
        .s_0        (s_0),
        .s_1        (s_1),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_level (fifo_level),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive the current cycle's inputs, then move to the sampling edge.
    task automatic step(input int p0, input int p1, input int junk);
        int ph;
        ph  = cyc % 5;
        s_0 = 10'(junk);
        s_1 = 10'(junk);
        if (ph == 2) s_0 = 10'(p0);
        if (ph == 4) s_1 = 10'(p1);
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input bit check);
        reset      = 1'b1;
        s_0        = '0;
        s_1        = '0;
        dout_ready = 1'b0;
        @(posedge clk);
        #1;
        if (check) begin
            @(negedge clk);
            chk("rst_dout_valid", 32'(dout_valid), 0);
            chk("rst_dout", 32'(dout), 0);
            chk("rst_level", 32'(fifo_level), 0);
            chk("rst_acc_out", 32'(acc_out), 0);
            chk("rst_acc_valid", 32'(acc_valid), 0);
            chk("rst_drop_err", 32'(drop_err), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    int cnt15;
    int last_pulse;
    int p0v;
    int p1v;

    initial begin
        do_reset(1'b1);

        // Full-scale products, consumer always ready.
        dout_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            step(961, 961, 0);
            if (cyc == 3 || cyc == 5 || cyc == 8 || cyc == 10) begin
                chk("t1_valid", 32'(dout_valid), 1);
                chk("t1_dout", 32'(dout), 961);
            end
            if (cyc == 4) chk("t1_gap_valid", 32'(dout_valid), 0);
            if (cyc == 9) chk("t1_acc_valid_early", 32'(acc_valid), 0);
            if (cyc == 10 || cyc == 20) begin
                chk("t1_acc_valid", 32'(acc_valid), 1);
                chk("t1_acc_out", 32'(acc_out), 3844);
            end
            if (cyc == 11 || cyc == 15) begin
                chk("t1_acc_pulse_end", 32'(acc_valid), 0);
                chk("t1_acc_hold", 32'(acc_out), 3844);
            end
            next_cyc();
        end

        // Small products with junk on non-capture phases.
        do_reset(1'b0);
        dout_ready = 1'b1;
        cnt15 = 0;
        for (int i = 0; i <= 10; i++) begin
            step(15, 15, 7);
            if (dout_valid && dout == 10'd15) cnt15++;
            if (cyc == 4) chk("t2_no_junk", 32'(dout_valid), 0);
            if (cyc == 10) begin
                chk("t2_acc_valid", 32'(acc_valid), 1);
                chk("t2_acc_out", 32'(acc_out), 60);
            end
            next_cyc();
        end
        chk("t2_count15", 32'(cnt15), 4);

        // Stalled consumer: fill, overflow, then drain.
        do_reset(1'b0);
        for (int i = 0; i <= 20; i++) begin
            dout_ready = (cyc >= 16);
            if (cyc < 16) step(961, 961, 0);
            else step(0, 0, 0);
            if (cyc == 10) begin
                chk("t3_level_full", 32'(fifo_level), 4);
                chk("t3_acc_valid", 32'(acc_valid), 1);
                chk("t3_acc_out", 32'(acc_out), 3844);
            end
            if (cyc == 12) chk("t3_no_drop_yet", 32'(drop_err), 0);
            if (cyc == 13) chk("t3_drop", 32'(drop_err), 1);
            if (cyc >= 16 && cyc <= 19) begin
                chk("t3_drain_valid", 32'(dout_valid), 1);
                chk("t3_drain_dout", 32'(dout), 961);
            end
            if (cyc == 20) chk("t3_drop_sticky", 32'(drop_err), 1);
            next_cyc();
        end

        // Full FIFO with pop and push in the same capture cycle.
        do_reset(1'b0);
        for (int i = 0; i <= 18; i++) begin
            dout_ready = (cyc >= 12);
            p0v = 101 + 2 * (cyc / 5);
            p1v = 102 + 2 * (cyc / 5);
            step(p0v, p1v, 0);
            if (cyc == 12) begin
                chk("t4_level_before", 32'(fifo_level), 4);
                chk("t4_head", 32'(dout), 101);
            end
            if (cyc == 13) chk("t4_level_after", 32'(fifo_level), 4);
            if (cyc >= 13 && cyc <= 17) chk("t4_order", 32'(dout), 32'(89 + cyc));
            if (cyc == 18) chk("t4_no_drop", 32'(drop_err), 0);
            next_cyc();
        end

        // Reset pulse mid-frame, mid-group.
        do_reset(1'b0);
        dout_ready = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            step(961, 961, 0);
            next_cyc();
        end
        reset = 1'b1;
        step(961, 961, 0);
        chk("t5_pre_reset_valid", 32'(dout_valid), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        for (int i = 0; i <= 10; i++) begin
            step(961, 961, 0);
            if (cyc == 0) begin
                chk("t5_dout_valid", 32'(dout_valid), 0);
                chk("t5_dout", 32'(dout), 0);
                chk("t5_level", 32'(fifo_level), 0);
                chk("t5_acc_out", 32'(acc_out), 0);
                chk("t5_drop", 32'(drop_err), 0);
            end
            if (cyc == 2) chk("t5_no_early_capture", 32'(dout_valid), 0);
            if (cyc == 3) chk("t5_first_capture", 32'(dout_valid), 1);
            if (cyc < 10) chk("t5_no_acc_valid", 32'(acc_valid), 0);
            if (cyc == 10) begin
                chk("t5_acc_valid", 32'(acc_valid), 1);
                chk("t5_acc_out", 32'(acc_out), 3844);
            end
            next_cyc();
        end

        // Alternating per-frame products 1 and 2.
        do_reset(1'b0);
        dout_ready = 1'b1;
        last_pulse = -1;
        for (int i = 0; i <= 30; i++) begin
            p0v = ((cyc / 5) % 2 == 1) ? 2 : 1;
            step(p0v, p0v, 0);
            if (cyc == 3 || cyc == 5 || cyc == 13) chk("t6_dout_one", 32'(dout), 1);
            if (cyc == 8 || cyc == 10) chk("t6_dout_two", 32'(dout), 2);
            if (cyc == 10 || cyc == 20 || cyc == 30) begin
                chk("t6_acc_valid", 32'(acc_valid), 1);
                chk("t6_acc_out", 32'(acc_out), 6);
            end
            if (cyc == 19 || cyc == 21 || cyc == 29) chk("t6_acc_quiet", 32'(acc_valid), 0);
            if (acc_valid) begin
                if (last_pulse >= 0) chk("t6_spacing", 32'(cyc - last_pulse), 10);
                last_pulse = cyc;
            end
            next_cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
